rca_adder: RTL and testbench
============================

RCA_ADDER -- requirements
Module: rca_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset; the port keeps the codebase name resetn, but the level 1 means reset asserted.
REQ-004 in_sum_a  input  DATA_WIDTH  addend A, sampled every clock.
REQ-005 in_sum_b  input  DATA_WIDTH  addend B, sampled every clock.
REQ-006 out_sum_result  output  DATA_WIDTH  registered sum, modulo 2^DATA_WIDTH.
REQ-007 out_sum_carry  output  1  registered carry-out (bit DATA_WIDTH of the true sum).

Function
REQ-008 Adder core SHALL be a ripple-carry chain of DATA_WIDTH one-bit full-adder cells, built with a generate loop.
REQ-009 Bit 0 carry-in SHALL be constant 0; each cell's carry-out SHALL feed the next cell's carry-in; the MSB carry-out is the carry result.
REQ-010 Full-adder cell: s = a XOR b XOR cin; cout = (a AND b) OR (cin AND (a XOR b)).
REQ-011 No behavioural "+" operator SHALL be used in the adder datapath.
REQ-012 Stage 1: input registers a_q, b_q SHALL capture in_sum_a and in_sum_b on every non-reset rising edge.
REQ-013 Stage 2: out_sum_result and out_sum_carry SHALL capture the ripple-carry result of a_q + b_q on every non-reset rising edge.
REQ-014 Latency: inputs sampled at edge N SHALL appear on the outputs immediately after edge N+1 (2 register stages, 2-cycle latency).
REQ-015 Throughput: one new operand pair per cycle, with no stalls and no handshake.
REQ-016 Overflow SHALL wrap: out_sum_result = (A+B) mod 2^DATA_WIDTH and out_sum_carry = 1 iff A+B >= 2^DATA_WIDTH.
REQ-017 Operands are unsigned; no signed-overflow flag is provided.
REQ-018 Outputs SHALL be driven only from registers, with no combinational path from inputs to outputs.
REQ-019 Outputs SHALL hold their values while the inputs are stable (steady state = registered sum of the held inputs).

Reset
REQ-020 When resetn=1 at a rising edge, a_q, b_q, out_sum_result and out_sum_carry SHALL all become 0 at that edge.
REQ-021 Reset has priority over data capture; any operand pairs in flight are discarded.
REQ-022 After resetn deasserts at edge R, the inputs are sampled at the first rising edge after R (call it R+1), and the first valid sum appears after edge R+2.
REQ-023 Until the first valid sum appears, the outputs SHALL read 0 (the registered sum of the reset value 0 + 0).
REQ-024 Reset asserted mid-stream SHALL force all outputs to 0 at the next edge, regardless of pipeline contents.

Verification
REQ-025 Reset: hold resetn=1 for 10 cycles with in_sum_a=in_sum_b=0xFFFFFFFF -> out_sum_result=0 and out_sum_carry=0 throughout.
REQ-026 Basic add: resetn=0; apply a=3, b=5 at edge N -> out_sum_result=8 and carry=0 after edge N+1.
REQ-027 Full carry ripple: a=0xFFFFFFFF, b=0x00000001 -> out_sum_result=0x00000000, carry=1; then a=0x7FFFFFFF, b=1 -> out_sum_result=0x80000000, carry=0.
REQ-028 Back-to-back stream: apply (1,2), (10,20), (0xFFFFFFFF,0xFFFFFFFF) on consecutive edges -> outputs 3, 30, 0xFFFFFFFE (carry=1) on consecutive cycles, 2 cycles delayed.
REQ-029 Reset mid-stream: while streaming a=b=0x12345678, assert resetn=1 for 1 cycle -> outputs 0 at that edge, and 0x2468ACF0 resumes 2 cycles after deassert.
REQ-030 Random: 1000 random pairs (including 4-bit range values as in system tests) compared against a 33-bit reference sum delayed by 2 cycles -> zero mismatches.

Source files
------------

// File: rtl/rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_adder
// Description : Two-stage pipelined unsigned adder. Stage 1 registers the
//               operands; stage 2 registers the result of a ripple-carry
//               chain of one-bit full-adder cells built over those registers.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,      // active-high despite the name
    input  logic [DATA_WIDTH-1:0] in_sum_a,
    input  logic [DATA_WIDTH-1:0] in_sum_b,
    output logic [DATA_WIDTH-1:0] out_sum_result,
    output logic                  out_sum_carry
);

    // Stage-1 operand registers
    logic [DATA_WIDTH-1:0] r_a_q;
    logic [DATA_WIDTH-1:0] r_b_q;

    // Ripple-carry chain: w_carry[i] is the carry into cell i,
    // w_carry[DATA_WIDTH] is the carry out of the MSB cell.
    logic [DATA_WIDTH:0]   w_carry;
    logic [DATA_WIDTH-1:0] w_sum;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
            logic w_prop;
            assign w_prop       = r_a_q[i] ^ r_b_q[i];
            assign w_sum[i]     = w_prop ^ w_carry[i];
            assign w_carry[i+1] = (r_a_q[i] & r_b_q[i]) | (w_carry[i] & w_prop);
        end
    endgenerate

    // Stage 1: capture operands every cycle; reset clears anything in flight
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            r_a_q <= in_sum_a;
            r_b_q <= in_sum_b;
        end
    end

    // Stage 2: register the ripple-carry result so outputs come only from flops
    always_ff @(posedge clk) begin
        if (resetn) begin
            out_sum_result <= '0;
            out_sum_carry  <= 1'b0;
        end else begin
            out_sum_result <= w_sum;
            out_sum_carry  <= w_carry[DATA_WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_adder
// Description : Self-checking bench for rca_adder (DATA_WIDTH = 32). A queue
//               holds the expected output of each operand pair entering the
//               pipeline and is popped as results emerge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_adder;

    localparam int DATA_WIDTH = 32;

    logic                  clk;
    logic                  resetn;
    logic [DATA_WIDTH-1:0] in_sum_a;
    logic [DATA_WIDTH-1:0] in_sum_b;
    logic [DATA_WIDTH-1:0] out_sum_result;
    logic                  out_sum_carry;

    int checks;
    int errors;

    // Expected {carry, sum} for each stage-1 entry, oldest first
    logic [DATA_WIDTH:0] sb_q[$];

    rca_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_sum_a       (in_sum_a),
        .in_sum_b       (in_sum_b),
        .out_sum_result (out_sum_result),
        .out_sum_carry  (out_sum_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance past the edge, then compare
    task automatic step(input logic [DATA_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] b,
                        input logic                  rst,
                        input string                 tag);
        logic [DATA_WIDTH:0] expv;
        logic [DATA_WIDTH:0] obs;
        in_sum_a = a;
        in_sum_b = b;
        resetn   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            // Outputs clear and stage 1 holds 0+0
            sb_q.delete();
            sb_q.push_back('0);
            expv = '0;
        end else begin
            sb_q.push_back({1'b0, a} + {1'b0, b});
            expv = sb_q.pop_front();
        end
        obs = {out_sum_carry, out_sum_result};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed carry/sum %h, expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b1;
        in_sum_a = '0;
        in_sum_b = '0;

        // Reset held with all-ones operands: outputs must stay 0
        for (int i = 0; i < 10; i++)
            step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "reset_hold");

        // Basic add, then hold inputs to show steady state
        step(32'd3, 32'd5, 1'b0, "basic_fill");
        step(32'd3, 32'd5, 1'b0, "basic_3p5");
        step(32'd3, 32'd5, 1'b0, "basic_hold");

        // Full-length carry ripple and MSB carry without overflow
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple_prev");
        step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "ripple_all");
        step(32'h0000_0000, 32'h0000_0000, 1'b0, "ripple_msb");
        step(32'h0000_0000, 32'h0000_0000, 1'b0, "zero_drain");

        // Back-to-back stream
        step(32'd1, 32'd2, 1'b0, "stream_1");
        step(32'd10, 32'd20, 1'b0, "stream_2");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "stream_3");
        step(32'd0, 32'd0, 1'b0, "stream_4");
        step(32'd0, 32'd0, 1'b0, "stream_5");

        // Reset mid-stream discards in-flight pairs
        for (int i = 0; i < 4; i++)
            step(32'h1234_5678, 32'h1234_5678, 1'b0, "midrst_pre");
        step(32'h1234_5678, 32'h1234_5678, 1'b1, "midrst_edge");
        step(32'h1234_5678, 32'h1234_5678, 1'b0, "midrst_r1");
        step(32'h1234_5678, 32'h1234_5678, 1'b0, "midrst_r2");
        step(32'h1234_5678, 32'h1234_5678, 1'b0, "midrst_r3");

        // Random pairs, a quarter of them restricted to 4-bit values
        for (int i = 0; i < 1000; i++) begin
            logic [DATA_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rb;
            if ($urandom_range(0, 3) == 0) begin
                ra = DATA_WIDTH'($urandom_range(0, 15));
                rb = DATA_WIDTH'($urandom_range(0, 15));
            end else begin
                ra = $urandom();
                rb = $urandom();
            end
            step(ra, rb, 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
